// File: rtl/psum_accumulator_pkg.sv
// Shared constants, FSM state encodings and the per-column ReLU helper
// for the psum accumulator.
package psum_accumulator_pkg;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int NIJ_MAX = 64;
  localparam int KIJ_BW  = 4;
  localparam int CNT_W   = 8;
  localparam int ROW_W   = COL * PSUM_BW;
  localparam int ADDR_W  = $clog2(NIJ_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // Zero every column whose sign bit is set when en is high.
  function automatic logic [ROW_W-1:0] relu_col(input logic [ROW_W-1:0] row,
                                                input logic en);
    logic [ROW_W-1:0] r;
    r = row;
    for (int c = 0; c < COL; c++)
      if (en && row[c*PSUM_BW + PSUM_BW - 1]) r[c*PSUM_BW +: PSUM_BW] = '0;
    return r;
  endfunction
endpackage

// File: rtl/psum_accumulator_buf.sv
// Psum row buffer: one synchronous write port, one asynchronous read port.
// Contents are not reset; every tile overwrites on its first kij pass.
module psum_buf
  import psum_accumulator_pkg::*;
#(
  parameter int DEPTH = NIJ_MAX,
  parameter int W     = ROW_W
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates OFIFO psum rows over kij passes into psum_buf, then drains
// the finished rows (optionally ReLU'd) through a registered valid/ready port.
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_nij_i,
  input  logic [KIJ_BW-1:0] num_kij_i,
  input  logic              relu_en_i,
  input  logic              ofifo_valid_i,
  input  logic [ROW_W-1:0]  ofifo_out_i,
  output logic              ofifo_rd_o,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [ROW_W-1:0]  out_data_o,
  output logic [CNT_W-1:0]  out_nij_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [KIJ_BW-1:0] KIJ_ONE = KIJ_BW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  nij_q, nij_d;
  logic [KIJ_BW-1:0] kij_q, kij_d;
  logic [CNT_W-1:0]  num_nij_q;
  logic [KIJ_BW-1:0] num_kij_q;
  logic              relu_q;
  logic              out_valid_q, out_valid_d;
  logic [ROW_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_nij_q, out_nij_d;
  logic [ROW_W-1:0]  rdata, wdata;
  logic              last_nij, last_kij, load, accept, accept_last;

  assign last_nij    = nij_q == num_nij_q - CNT_ONE;
  assign last_kij    = kij_q == num_kij_q - KIJ_ONE;
  assign accept      = out_valid_q && out_ready_i;
  assign accept_last = (state_q == S_DRAIN) && accept && (out_nij_q == num_nij_q - CNT_ONE);
  // nij_q doubles as the drain read pointer; it stops once every row is loaded.
  assign load        = (state_q == S_DRAIN) && (!out_valid_q || out_ready_i) &&
                       (nij_q != num_nij_q);

  psum_buf u_buf (
    .clk_i   (clk_i),
    .we_i    (ofifo_rd_o),
    .waddr_i (nij_q[ADDR_W-1:0]),
    .wdata_i (wdata),
    .raddr_i (nij_q[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  for (genvar c = 0; c < COL; c++) begin : g_col
    logic [PSUM_BW-1:0] prev;
    assign prev = (kij_q == '0) ? '0 : rdata[c*PSUM_BW +: PSUM_BW];
    assign wdata[c*PSUM_BW +: PSUM_BW] = prev + ofifo_out_i[c*PSUM_BW +: PSUM_BW];
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (num_nij_i == '0) ? S_FINISH : S_ACCUM;
      S_ACCUM: if (ofifo_rd_o && last_nij && last_kij) state_d = S_DRAIN;
      S_DRAIN: if (accept_last) state_d = S_FINISH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ofifo_rd_o = (state_q == S_ACCUM) && ofifo_valid_i;
    busy_o     = state_q != S_IDLE;
    done_o     = state_q == S_FINISH;
  end

  always_comb begin
    nij_d       = nij_q;
    kij_d       = kij_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nij_d   = out_nij_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        nij_d = '0;
        kij_d = '0;
      end
      S_ACCUM: if (ofifo_rd_o) begin
        if (last_nij) begin
          nij_d = '0;
          kij_d = last_kij ? '0 : kij_q + KIJ_ONE;
        end else begin
          nij_d = nij_q + CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = relu_col(rdata, relu_q);
          out_nij_d   = nij_q;
          nij_d       = nij_q + CNT_ONE;
        end else if (accept) begin
          out_valid_d = 1'b0;
        end
      end
      default: nij_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      nij_q       <= '0;
      kij_q       <= '0;
      num_nij_q   <= '0;
      num_kij_q   <= KIJ_ONE;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nij_q   <= '0;
    end else begin
      nij_q       <= nij_d;
      kij_q       <= kij_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nij_q   <= out_nij_d;
      if (state_q == S_IDLE && start_i) begin
        num_nij_q <= num_nij_i;
        num_kij_q <= (num_kij_i == '0) ? KIJ_ONE : num_kij_i;
        relu_q    <= relu_en_i;
      end
    end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_nij_o   = out_nij_q;
endmodule
